// File: rtl/sensor_timing_ctrl.sv
// Sensor timing controller: sequences sensor reset, start/stop/single streaming and
// frame-boundary application of shadowed timing registers. Optional feature: CONTINUE_LVAL_EN.
module sensor_timing_ctrl #(
  parameter int unsigned RST_CYCLES      = 32'd8,
  parameter logic [15:0] DEF_WIDTH       = 16'd64,
  parameter logic [15:0] DEF_LINE_HIDE   = 16'd10,
  parameter logic [15:0] DEF_HEIGHT      = 16'd16,
  parameter logic [15:0] DEF_FRAME_HIDE  = 16'd20,
  parameter logic [15:0] DEF_FRONT_PORCH = 16'd2,
  parameter logic [15:0] DEF_BACK_PORCH  = 16'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_fval,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_single,
  input  logic        i_cfg_wr,
  input  logic [2:0]  iv_cfg_addr,
  input  logic [15:0] iv_cfg_data,
  output logic        o_sensor_reset,
  output logic        o_pause_en,
  output logic        o_continue_lval,
  output logic [15:0] ov_width,
  output logic [15:0] ov_line_hide,
  output logic [15:0] ov_height,
  output logic [15:0] ov_frame_hide,
  output logic [15:0] ov_front_porch,
  output logic [15:0] ov_back_porch,
  output logic        o_cfg_pending,
  output logic        o_frame_done,
  output logic [15:0] ov_frame_cnt
);

  typedef enum logic [1:0] {S_RST = 2'd0, S_IDLE = 2'd1, S_RUN = 2'd2, S_STOP = 2'd3} state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 32'd1);

  state_t      state_r, state_nxt_s;
  logic        single_r, single_nxt_s;
  logic        fval_d_r, fall_s, in_frame_s, wr_valid_s, apply_s;
  logic [15:0] rst_cnt_r;
  logic        sensor_reset_r, pause_en_r, pending_r, frame_done_r;
  logic [15:0] frame_cnt_r;
  logic [15:0] sh_width_r, sh_line_hide_r, sh_height_r, sh_frame_hide_r, sh_front_r, sh_back_r;
  logic [15:0] act_width_r, act_line_hide_r, act_height_r, act_frame_hide_r, act_front_r, act_back_r;

  assign fall_s     = fval_d_r & ~i_fval;
  assign in_frame_s = (state_r == S_RUN) || (state_r == S_STOP);
  assign apply_s    = pending_r && ((state_r == S_IDLE) || (fall_s && in_frame_s));

  // Next-state and single-frame flag decode
  always_comb begin
    state_nxt_s  = state_r;
    single_nxt_s = single_r;
    case (state_r)
      S_RST: begin
        if (rst_cnt_r == RST_LAST) state_nxt_s = S_IDLE;
        else                       state_nxt_s = S_RST;
      end
      S_IDLE: begin
        if (i_single) begin
          state_nxt_s  = S_RUN;
          single_nxt_s = 1'b1;
        end else if (i_start) begin
          state_nxt_s  = S_RUN;
          single_nxt_s = 1'b0;
        end else begin
          state_nxt_s  = S_IDLE;
        end
      end
      S_RUN: begin
        if (fall_s && single_r) begin
          state_nxt_s  = S_IDLE;
          single_nxt_s = 1'b0;
        end else if (i_stop) begin
          state_nxt_s  = S_STOP;
        end else begin
          state_nxt_s  = S_RUN;
        end
      end
      S_STOP: begin
        // An idle sensor leaves at once; an active frame leaves on its falling edge
        if ((!i_fval && !fval_d_r) || fall_s) begin
          state_nxt_s  = S_IDLE;
          single_nxt_s = 1'b0;
        end else begin
          state_nxt_s  = S_STOP;
        end
      end
      default: begin
        state_nxt_s  = S_RST;
        single_nxt_s = 1'b0;
      end
    endcase
  end

  // Qualify configuration writes by address
  always_comb begin
    wr_valid_s = 1'b0;
    if (i_cfg_wr) begin
      case (iv_cfg_addr)
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: wr_valid_s = 1'b1;
`ifdef CONTINUE_LVAL_EN
        3'd6:                               wr_valid_s = 1'b1;
`endif
        default:                            wr_valid_s = 1'b0;
      endcase
    end else begin
      wr_valid_s = 1'b0;
    end
  end

  // FSM state, reset sequencing counter and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_RST;
      single_r       <= 1'b0;
      fval_d_r       <= 1'b0;
      rst_cnt_r      <= 16'd0;
      sensor_reset_r <= 1'b1;
      pause_en_r     <= 1'b1;
    end else begin
      state_r        <= state_nxt_s;
      single_r       <= single_nxt_s;
      fval_d_r       <= i_fval;
      rst_cnt_r      <= (state_r == S_RST) ? rst_cnt_r + 16'd1 : 16'd0;
      sensor_reset_r <= (state_nxt_s == S_RST);
      pause_en_r     <= (state_nxt_s == S_RST) || (state_nxt_s == S_IDLE);
    end
  end

  // Frame completion pulse and wrapping frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done_r <= 1'b0;
      frame_cnt_r  <= 16'd0;
    end else begin
      frame_done_r <= fall_s && in_frame_s;
      if (fall_s && in_frame_s) frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end

  // Shadow registers; a write coinciding with an apply keeps pending set
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_width_r      <= DEF_WIDTH;
      sh_line_hide_r  <= DEF_LINE_HIDE;
      sh_height_r     <= DEF_HEIGHT;
      sh_frame_hide_r <= DEF_FRAME_HIDE;
      sh_front_r      <= DEF_FRONT_PORCH;
      sh_back_r       <= DEF_BACK_PORCH;
      pending_r       <= 1'b0;
    end else begin
      if (i_cfg_wr) begin
        case (iv_cfg_addr)
          3'd0:    sh_width_r      <= iv_cfg_data;
          3'd1:    sh_line_hide_r  <= iv_cfg_data;
          3'd2:    sh_height_r     <= iv_cfg_data;
          3'd3:    sh_frame_hide_r <= iv_cfg_data;
          3'd4:    sh_front_r      <= iv_cfg_data;
          3'd5:    sh_back_r       <= iv_cfg_data;
          default: ;
        endcase
      end
      if (wr_valid_s)   pending_r <= 1'b1;
      else if (apply_s) pending_r <= 1'b0;
    end
  end

  // Active registers take the pre-write shadow contents on apply
  always_ff @(posedge clk) begin
    if (reset) begin
      act_width_r      <= DEF_WIDTH;
      act_line_hide_r  <= DEF_LINE_HIDE;
      act_height_r     <= DEF_HEIGHT;
      act_frame_hide_r <= DEF_FRAME_HIDE;
      act_front_r      <= DEF_FRONT_PORCH;
      act_back_r       <= DEF_BACK_PORCH;
    end else if (apply_s) begin
      act_width_r      <= sh_width_r;
      act_line_hide_r  <= sh_line_hide_r;
      act_height_r     <= sh_height_r;
      act_frame_hide_r <= sh_frame_hide_r;
      act_front_r      <= sh_front_r;
      act_back_r       <= sh_back_r;
    end
  end

`ifdef CONTINUE_LVAL_EN
  logic sh_cont_r, act_cont_r;

  // Continue-lval mode bit follows the same shadow/apply path
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_cont_r  <= 1'b0;
      act_cont_r <= 1'b0;
    end else begin
      if (i_cfg_wr && (iv_cfg_addr == 3'd6)) sh_cont_r <= iv_cfg_data[0];
      if (apply_s) act_cont_r <= sh_cont_r;
    end
  end

  assign o_continue_lval = act_cont_r;
`else
  assign o_continue_lval = 1'b0;
`endif

  assign o_sensor_reset = sensor_reset_r;
  assign o_pause_en     = pause_en_r;
  assign o_cfg_pending  = pending_r;
  assign o_frame_done   = frame_done_r;
  assign ov_frame_cnt   = frame_cnt_r;
  assign ov_width       = act_width_r;
  assign ov_line_hide   = act_line_hide_r;
  assign ov_height      = act_height_r;
  assign ov_frame_hide  = act_frame_hide_r;
  assign ov_front_porch = act_front_r;
  assign ov_back_porch  = act_back_r;

endmodule

// File: tb/tb_sensor_timing_ctrl.sv
// Self-checking bench for sensor_timing_ctrl: frame-done scoreboard plus direct checks
// of reset sequencing, shadow/apply timing, stop/single control and counter wrap.
module tb_sensor_timing_ctrl;

  logic        clk = 1'b0;
  logic        reset, i_fval, i_start, i_stop, i_single, i_cfg_wr;
  logic [2:0]  iv_cfg_addr;
  logic [15:0] iv_cfg_data;
  logic        o_sensor_reset, o_pause_en, o_continue_lval, o_cfg_pending, o_frame_done;
  logic [15:0] ov_width, ov_line_hide, ov_height, ov_frame_hide, ov_front_porch, ov_back_porch;
  logic [15:0] ov_frame_cnt;

`ifdef CONTINUE_LVAL_EN
  localparam logic CONT_EXP = 1'b1;
`else
  localparam logic CONT_EXP = 1'b0;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt  = 16'd0;
  logic [15:0] sb_q[$];

  sensor_timing_ctrl dut (
    .clk(clk), .reset(reset), .i_fval(i_fval), .i_start(i_start), .i_stop(i_stop),
    .i_single(i_single), .i_cfg_wr(i_cfg_wr), .iv_cfg_addr(iv_cfg_addr),
    .iv_cfg_data(iv_cfg_data), .o_sensor_reset(o_sensor_reset), .o_pause_en(o_pause_en),
    .o_continue_lval(o_continue_lval), .ov_width(ov_width), .ov_line_hide(ov_line_hide),
    .ov_height(ov_height), .ov_frame_hide(ov_frame_hide), .ov_front_porch(ov_front_porch),
    .ov_back_porch(ov_back_porch), .o_cfg_pending(o_cfg_pending),
    .o_frame_done(o_frame_done), .ov_frame_cnt(ov_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
    i_cfg_wr = 1'b1; iv_cfg_addr = addr; iv_cfg_data = data;
    @(negedge clk);
    i_cfg_wr = 1'b0;
  endtask

  task automatic pulse(input bit start, input bit stop, input bit single);
    i_start = start; i_stop = stop; i_single = single;
    @(negedge clk);
    i_start = 1'b0; i_stop = 1'b0; i_single = 1'b0;
  endtask

  // Frame of len active cycles; a counted frame queues its expected count at the fall
  task automatic run_frame(input int len, input bit counted);
    i_fval = 1'b1;
    tick(len);
    i_fval = 1'b0;
    if (counted) begin
      exp_cnt = exp_cnt + 16'd1;
      sb_q.push_back(exp_cnt);
    end
    @(negedge clk);
  endtask

  // Each frame_done pulse must match the oldest queued count
  always @(negedge clk) begin
    if (o_frame_done === 1'b1) begin
      if (sb_q.size() == 0) check_eq("unexpected_done", 32'd1, 32'd0);
      else                  check_eq("frame_cnt_at_done", ov_frame_cnt, sb_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; i_fval = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_single = 1'b0;
    i_cfg_wr = 1'b0; iv_cfg_addr = 3'd0; iv_cfg_data = 16'd0;
    tick(2);
    check_eq("rst_sensor_reset", o_sensor_reset, 1'b1);
    check_eq("rst_pause", o_pause_en, 1'b1);
    check_eq("rst_width", ov_width, 16'd64);
    check_eq("rst_line_hide", ov_line_hide, 16'd10);
    check_eq("rst_pending", o_cfg_pending, 1'b0);
    check_eq("rst_frame_cnt", ov_frame_cnt, 16'd0);
    check_eq("rst_frame_done", o_frame_done, 1'b0);
    check_eq("rst_cont_lval", o_continue_lval, 1'b0);
    reset = 1'b0;
    n = 0;
    while (o_sensor_reset === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_eq("sensor_reset_len", n, 32'd8);
    check_eq("idle_pause", o_pause_en, 1'b1);
    check_eq("idle_width", ov_width, 16'd64);
    check_eq("idle_height", ov_height, 16'd16);
    check_eq("idle_frame_hide", ov_frame_hide, 16'd20);
    check_eq("idle_porches", {ov_front_porch, ov_back_porch}, {16'd2, 16'd2});

    // Out-of-range and continue-lval writes in idle
    cfg_write(3'd7, 16'h1234);
    check_eq("addr7_pending", o_cfg_pending, 1'b0);
    cfg_write(3'd6, 16'h0001);
    check_eq("addr6_pending", o_cfg_pending, CONT_EXP);
    tick(1);
    check_eq("cont_lval", o_continue_lval, CONT_EXP);
    check_eq("addr6_applied", o_cfg_pending, 1'b0);

    // Single frame, with start and stop in the same cycle
    pulse(1'b1, 1'b1, 1'b1);
    check_eq("single_pause_low", o_pause_en, 1'b0);
    i_fval = 1'b1;
    tick(50);
    check_eq("single_mid_pause", o_pause_en, 1'b0);
    tick(50);
    i_fval = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    sb_q.push_back(exp_cnt);
    tick(1);
    check_eq("single_back_idle", o_pause_en, 1'b1);
    check_eq("single_cnt", ov_frame_cnt, 16'd1);
    run_frame(10, 1'b0);
    tick(2);
    check_eq("idle_frame_ignored", ov_frame_cnt, 16'd1);

    // Width write held off until the frame ends
    pulse(1'b1, 1'b0, 1'b0);
    i_fval = 1'b1;
    tick(5);
    cfg_write(3'd0, 16'd128);
    tick(3);
    check_eq("hold_width", ov_width, 16'd64);
    check_eq("hold_pending", o_cfg_pending, 1'b1);
    i_fval = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    sb_q.push_back(exp_cnt);
    tick(1);
    check_eq("applied_width", ov_width, 16'd128);
    check_eq("applied_pending", o_cfg_pending, 1'b0);

    // Write coinciding with an apply
    tick(2);
    i_fval = 1'b1;
    tick(4);
    cfg_write(3'd2, 16'd32);
    tick(4);
    check_eq("pre_apply_height", ov_height, 16'd16);
    i_fval = 1'b0;
    i_cfg_wr = 1'b1; iv_cfg_addr = 3'd2; iv_cfg_data = 16'd48;
    exp_cnt = exp_cnt + 16'd1;
    sb_q.push_back(exp_cnt);
    tick(1);
    i_cfg_wr = 1'b0;
    check_eq("collide_height", ov_height, 16'd32);
    check_eq("collide_pending", o_cfg_pending, 1'b1);

    // Stop mid-frame finishes the frame and applies the later write
    tick(2);
    i_fval = 1'b1;
    tick(5);
    pulse(1'b0, 1'b1, 1'b0);
    tick(5);
    check_eq("stop_pause_low", o_pause_en, 1'b0);
    check_eq("stop_height_hold", ov_height, 16'd32);
    i_fval = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    sb_q.push_back(exp_cnt);
    tick(1);
    check_eq("stop_pause_high", o_pause_en, 1'b1);
    check_eq("stop_height", ov_height, 16'd48);
    check_eq("stop_cnt", ov_frame_cnt, 16'd4);

    // Stop while the sensor is idle
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_eq("stop_idle_wait", o_pause_en, 1'b0);
    tick(1);
    check_eq("stop_idle_done", o_pause_en, 1'b1);

    // Counter wrap
    force dut.frame_cnt_r = 16'hFFFF;
    tick(1);
    release dut.frame_cnt_r;
    tick(1);
    check_eq("preload_cnt", ov_frame_cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    pulse(1'b1, 1'b0, 1'b0);
    run_frame(5, 1'b1);
    check_eq("wrap_cnt", ov_frame_cnt, 16'd0);
    pulse(1'b0, 1'b1, 1'b0);
    tick(2);

    // Reset mid-frame abandons frame and pending writes
    pulse(1'b1, 1'b0, 1'b0);
    i_fval = 1'b1;
    tick(3);
    cfg_write(3'd0, 16'd200);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    i_fval = 1'b0;
    check_eq("midrst_width", ov_width, 16'd64);
    check_eq("midrst_pending", o_cfg_pending, 1'b0);
    tick(12);
    check_eq("midrst_width_idle", ov_width, 16'd64);
    check_eq("midrst_cnt", ov_frame_cnt, 16'd0);
    check_eq("midrst_sensor_reset", o_sensor_reset, 1'b0);
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
